mbisr_repair_map: RTL and testbench
===================================

Name: mbisr_repair_map

Overview:
- Built-in self-repair stage directly downstream of the MBIST engine.
- Collects failing word addresses reported by MBIST during a test run and allocates each unique one to a spare word register.
- After MBIST completes, sits between the functional port and the main SRAM macro: transparently redirects accesses to repaired addresses into the spares.
- Reports repair status (done / unrepairable / spares used) to the top-level status outputs.

Parameters:
- ADDR_W, 4, word-address width of the protected memory
- DATA_W, 8, data word width
- NUM_SPARES, 2, number of spare word registers (1..8)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  sync pulse: empty the repair map and return to COLLECT
- fail_valid  in  1  MBIST fail report valid
- fail_addr  in  ADDR_W  failing word address
- fail_ready  out  1  map can accept a fail report
- bist_done  in  1  sync pulse from MBIST: test run finished
- func_addr  in  ADDR_W  functional access address
- func_we  in  1  functional write enable
- func_wdata  in  DATA_W  functional write data
- func_rdata  out  DATA_W  functional read data, 1-cycle latency
- mem_addr  out  ADDR_W  to SRAM (registered pass-through of func_addr)
- mem_we  out  1  to SRAM write enable
- mem_wdata  out  DATA_W  to SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid 1 cycle after mem_addr
- repair_done  out  1  map resolved, remap active
- repair_fail  out  1  sticky: more unique fails than spares
- spares_used  out  clog2(NUM_SPARES+1)  count of allocated spares

Behaviour:
- Reset (async, rst=1): state COLLECT; all entry valid bits 0; spare data 0; fail_ready=1; repair_done=0; repair_fail=0; spares_used=0; func_rdata=0; mem_we=0; mem_addr=0; mem_wdata=0.
- FSM states: COLLECT, CAPTURE, DONE.
- COLLECT:
  - fail_ready=1.
  - A report is accepted on a cycle with fail_valid && fail_ready: latch fail_addr, go to CAPTURE.
- CAPTURE (exactly 1 cycle, fail_ready=0):
  - Compare the latched address against all valid entries.
  - Hit: no change (duplicate).
  - Miss with a free entry: write the lowest-index free entry, set its valid bit, spares_used+1.
  - Miss with no free entry: set repair_fail; map unchanged.
  - Return to COLLECT.
  - MBIST must hold fail_valid/fail_addr until it sees fail_ready; reports are never dropped.
- bist_done:
  - Sampled in COLLECT: go to DONE, repair_done=1 next cycle.
  - Sampled in CAPTURE: remembered; the capture completes first, then go directly to DONE.
  - Same cycle as an accepted fail in COLLECT: the fail is captured first, then DONE.
  - Ignored in DONE.
- DONE: fail_ready=0; fail_valid ignored; repair_done=1 (also held when repair_fail=1).
- Functional path, active in DONE only; in COLLECT/CAPTURE it is a pure registered pass-through with no remap:
  - Cycle T:
    - Address compare against valid entries.
    - mem_addr/mem_wdata register func_addr/func_wdata.
    - mem_we registers func_we && !hit.
    - Write hit: spare[idx] <= func_wdata at T's edge; SRAM not written.
  - Cycle T+1:
    - func_rdata = spare[idx_reg] if hit_reg, else mem_rdata (combinational mux on registered select).
    - Read-after-write to the same spare returns the new data.
- clear: from any state, next cycle returns to reset values except func_rdata/mem_* path registers; clear has priority over fail_valid and bist_done.
- Widths: spares_used saturates at NUM_SPARES; repair_fail stays 1 until rst or clear.

Test Plan:
- Reset mid-CAPTURE:
  - Stimulus: rst during a CAPTURE cycle.
  - Required: all outputs at reset values immediately, spares_used=0, fail_ready=1.
- Two unique fails then done:
  - Stimulus: fail_addr 3, then 9; bist_done.
  - Required: fail_ready low 1 cycle after each acceptance, spares_used=2, repair_done=1, repair_fail=0.
- Duplicate and overflow:
  - Stimulus: fails 5, 5, 6, 7 with NUM_SPARES=2.
  - Required: spares_used=2; repair_fail=1 after the capture of 7; entries hold 5 and 6.
- Remap write/read in DONE (map {3,9}):
  - Stimulus: write 0xA5 to addr 3, then read addr 3.
  - Required: mem_we=0 on the write; read returns 0xA5 next cycle.
  - Stimulus: write 0x3C to addr 4, then read addr 4.
  - Required: mem_we=1, mem_addr=4; func_rdata=mem_rdata.
- Simultaneous events:
  - Stimulus: fail 2 accepted in the same cycle as bist_done.
  - Required: addr 2 captured (spares_used=1) before repair_done=1.
  - Stimulus: clear asserted together with fail_valid.
  - Required: report not accepted; spares_used=0, state COLLECT.
- Pass-through before done:
  - Stimulus: write/read addr 3 in COLLECT with 3 already captured.
  - Required: SRAM accessed (mem_we=1); func_rdata=mem_rdata.

Source files
------------

// File: rtl/mbisr_repair_map_if.sv
// mbisr_repair_map_if: MBIST fail reports, functional port, SRAM port and repair status.
interface mbisr_repair_map_if #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int NUM_SPARES = 2
);
    localparam int CNT_W = $clog2(NUM_SPARES + 1);
    logic              clear;
    logic              fail_valid;
    logic [ADDR_W-1:0] fail_addr;
    logic              fail_ready;
    logic              bist_done;
    logic [ADDR_W-1:0] func_addr;
    logic              func_we;
    logic [DATA_W-1:0] func_wdata;
    logic [DATA_W-1:0] func_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              repair_done;
    logic              repair_fail;
    logic [CNT_W-1:0]  spares_used;

    modport master (
        output clear, fail_valid, fail_addr, bist_done, func_addr, func_we, func_wdata, mem_rdata,
        input  fail_ready, func_rdata, mem_addr, mem_we, mem_wdata, repair_done, repair_fail, spares_used
    );
    modport slave (
        input  clear, fail_valid, fail_addr, bist_done, func_addr, func_we, func_wdata, mem_rdata,
        output fail_ready, func_rdata, mem_addr, mem_we, mem_wdata, repair_done, repair_fail, spares_used
    );
endinterface

// File: rtl/mbisr_repair_map.sv
// mbisr_repair_map: allocates MBIST-reported failing words to spare registers and
// redirects functional accesses to repaired addresses once the test run is done.
module mbisr_repair_map #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int NUM_SPARES = 2
) (
    input logic               clk,
    input logic               rst,
    mbisr_repair_map_if.slave bus
);
    localparam int IDX_W = NUM_SPARES > 1 ? $clog2(NUM_SPARES) : 1;
    localparam int CNT_W = $clog2(NUM_SPARES + 1);

    typedef enum logic [1:0] {COLLECT, CAPTURE, DONE} state_t;

    state_t            r_state;
    logic [NUM_SPARES-1:0] r_valid;
    logic [ADDR_W-1:0] r_tag  [NUM_SPARES];
    logic [DATA_W-1:0] r_data [NUM_SPARES];
    logic [ADDR_W-1:0] r_cap_addr;
    logic              r_done_pend;
    logic              r_fail_ready;
    logic              r_repair_done;
    logic              r_repair_fail;
    logic [CNT_W-1:0]  r_used;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_hit_q;
    logic [IDX_W-1:0]  r_idx_q;
    logic              r_live;
    logic              w_cap_hit;
    logic              w_free;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_hit;
    logic [IDX_W-1:0]  w_idx;
    logic              w_to_done;

    // Descending scan so the lowest matching/free index wins.
    always_comb begin
        w_cap_hit  = 1'b0;
        w_free     = 1'b0;
        w_free_idx = '0;
        w_hit      = 1'b0;
        w_idx      = '0;
        for (int i = NUM_SPARES - 1; i >= 0; i--) begin
            if (r_valid[i] && r_tag[i] == r_cap_addr) w_cap_hit = 1'b1;
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_state == DONE && r_valid[i] && r_tag[i] == bus.func_addr) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i);
            end
        end
    end

    assign w_to_done = r_done_pend || bus.bist_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= COLLECT;
            r_valid       <= '0;
            r_cap_addr    <= '0;
            r_done_pend   <= 1'b0;
            r_fail_ready  <= 1'b1;
            r_repair_done <= 1'b0;
            r_repair_fail <= 1'b0;
            r_used        <= '0;
            r_mem_addr    <= '0;
            r_mem_we      <= 1'b0;
            r_mem_wdata   <= '0;
            r_hit_q       <= 1'b0;
            r_idx_q       <= '0;
            r_live        <= 1'b0;
            for (int i = 0; i < NUM_SPARES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_live      <= 1'b1;
            r_mem_addr  <= bus.func_addr;
            r_mem_wdata <= bus.func_wdata;
            r_mem_we    <= bus.func_we && !w_hit;
            r_hit_q     <= w_hit;
            r_idx_q     <= w_idx;
            if (bus.clear) begin
                r_state       <= COLLECT;
                r_valid       <= '0;
                r_done_pend   <= 1'b0;
                r_fail_ready  <= 1'b1;
                r_repair_done <= 1'b0;
                r_repair_fail <= 1'b0;
                r_used        <= '0;
                for (int i = 0; i < NUM_SPARES; i++) r_data[i] <= '0;
            end else begin
                if (w_hit && bus.func_we) r_data[w_idx] <= bus.func_wdata;
                case (r_state)
                    COLLECT: begin
                        if (bus.fail_valid) begin
                            r_cap_addr   <= bus.fail_addr;
                            r_done_pend  <= bus.bist_done;
                            r_fail_ready <= 1'b0;
                            r_state      <= CAPTURE;
                        end else if (bus.bist_done) begin
                            r_fail_ready  <= 1'b0;
                            r_repair_done <= 1'b1;
                            r_state       <= DONE;
                        end
                    end
                    CAPTURE: begin
                        if (!w_cap_hit && w_free) begin
                            r_valid[w_free_idx] <= 1'b1;
                            r_tag[w_free_idx]   <= r_cap_addr;
                            r_used              <= r_used + 1'b1;
                        end else if (!w_cap_hit) begin
                            r_repair_fail <= 1'b1;
                        end
                        r_done_pend   <= 1'b0;
                        r_fail_ready  <= !w_to_done;
                        r_repair_done <= w_to_done;
                        r_state       <= w_to_done ? DONE : COLLECT;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.fail_ready  = r_fail_ready;
    assign bus.repair_done = r_repair_done;
    assign bus.repair_fail = r_repair_fail;
    assign bus.spares_used = r_used;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.func_rdata  = !r_live ? '0 : r_hit_q ? r_data[r_idx_q] : bus.mem_rdata;
endmodule

// File: tb/tb_mbisr_repair_map.sv
// tb_mbisr_repair_map: directed vectors for the repair map, table-driven functional checks.
module tb_mbisr_repair_map;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    mbisr_repair_map_if #(.ADDR_W(4), .DATA_W(8), .NUM_SPARES(2)) bus ();
    mbisr_repair_map #(.ADDR_W(4), .DATA_W(8), .NUM_SPARES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] mrd;
        logic       exp_we;
        logic [7:0] exp_rd;
    } fvec_t;

    fvec_t done_vec [7];
    fvec_t ovf_vec  [3];
    fvec_t pre_vec  [2];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_func(input fvec_t v, input string tag);
        bus.func_we    = v.we;
        bus.func_addr  = v.addr;
        bus.func_wdata = v.wdata;
        bus.mem_rdata  = v.mrd;
        tick();
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'(v.exp_we));
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(v.addr));
        chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(v.wdata));
        chk({tag, "_rdata"}, 32'(bus.func_rdata), 32'(v.exp_rd));
        bus.func_we = 1'b0;
    endtask

    task automatic send_fail(input logic [3:0] a, input logic bd);
        int n = 0;
        bus.fail_valid = 1'b1;
        bus.fail_addr  = a;
        while (!bus.fail_ready && n < 10) begin
            tick();
            n++;
        end
        if (!bus.fail_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        bus.bist_done = bd;
        tick();
        bus.fail_valid = 1'b0;
        bus.bist_done  = 1'b0;
        chk("capture_ready_low", 32'(bus.fail_ready), 0);
        chk("capture_not_done", 32'(bus.repair_done), 0);
        tick();
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(bus.fail_ready), 1);
        chk({tag, "_done"}, 32'(bus.repair_done), 0);
        chk({tag, "_fail"}, 32'(bus.repair_fail), 0);
        chk({tag, "_used"}, 32'(bus.spares_used), 0);
        chk({tag, "_rdata"}, 32'(bus.func_rdata), 0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        done_vec[0] = '{1'b1, 4'd3, 8'hA5, 8'h11, 1'b0, 8'hA5};
        done_vec[1] = '{1'b0, 4'd3, 8'h00, 8'h22, 1'b0, 8'hA5};
        done_vec[2] = '{1'b1, 4'd4, 8'h3C, 8'h33, 1'b1, 8'h33};
        done_vec[3] = '{1'b0, 4'd4, 8'h00, 8'h3C, 1'b0, 8'h3C};
        done_vec[4] = '{1'b1, 4'd9, 8'h77, 8'h44, 1'b0, 8'h77};
        done_vec[5] = '{1'b0, 4'd3, 8'h00, 8'h55, 1'b0, 8'hA5};
        done_vec[6] = '{1'b0, 4'd9, 8'h00, 8'h66, 1'b0, 8'h77};
        ovf_vec[0]  = '{1'b1, 4'd5, 8'h12, 8'h81, 1'b0, 8'h12};
        ovf_vec[1]  = '{1'b1, 4'd6, 8'h34, 8'h82, 1'b0, 8'h34};
        ovf_vec[2]  = '{1'b1, 4'd7, 8'h56, 8'h83, 1'b1, 8'h83};
        pre_vec[0]  = '{1'b1, 4'd3, 8'h61, 8'h10, 1'b1, 8'h10};
        pre_vec[1]  = '{1'b0, 4'd3, 8'h00, 8'h61, 1'b0, 8'h61};

        rst = 1'b1;
        bus.clear = 1'b0;
        bus.fail_valid = 1'b0;
        bus.fail_addr = '0;
        bus.bist_done = 1'b0;
        bus.func_addr = '0;
        bus.func_we = 1'b0;
        bus.func_wdata = '0;
        bus.mem_rdata = 8'hFF;
        repeat (2) tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Two unique fails then done.
        send_fail(4'd3, 1'b0);
        chk("f3_used", 32'(bus.spares_used), 1);
        chk("f3_ready_back", 32'(bus.fail_ready), 1);
        send_fail(4'd9, 1'b0);
        chk("f9_used", 32'(bus.spares_used), 2);
        bus.bist_done = 1'b1;
        tick();
        bus.bist_done = 1'b0;
        chk("two_done", 32'(bus.repair_done), 1);
        chk("two_fail", 32'(bus.repair_fail), 0);
        chk("two_used", 32'(bus.spares_used), 2);
        chk("two_ready", 32'(bus.fail_ready), 0);

        for (int i = 0; i < 7; i++) apply_func(done_vec[i], $sformatf("done%0d", i));

        // Reports and bist_done are ignored once done.
        bus.fail_valid = 1'b1;
        bus.fail_addr = 4'd1;
        bus.bist_done = 1'b1;
        repeat (2) tick();
        bus.fail_valid = 1'b0;
        bus.bist_done = 1'b0;
        chk("done_ign_used", 32'(bus.spares_used), 2);
        chk("done_ign_ready", 32'(bus.fail_ready), 0);
        chk("done_ign_done", 32'(bus.repair_done), 1);

        // Clear from DONE, then async reset while in CAPTURE.
        pulse_clear();
        chk("clr_done_ready", 32'(bus.fail_ready), 1);
        chk("clr_done_done", 32'(bus.repair_done), 0);
        chk("clr_done_used", 32'(bus.spares_used), 0);
        bus.fail_valid = 1'b1;
        bus.fail_addr = 4'd1;
        bus.func_we = 1'b1;
        bus.func_addr = 4'd2;
        bus.func_wdata = 8'h99;
        bus.mem_rdata = 8'hEE;
        tick();
        bus.fail_valid = 1'b0;
        chk("midcap_ready", 32'(bus.fail_ready), 0);
        chk("midcap_mem_we", 32'(bus.mem_we), 1);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("midcap_rst");
        bus.func_we = 1'b0;
        bus.func_addr = '0;
        bus.func_wdata = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("midcap_after_used", 32'(bus.spares_used), 0);
        chk("midcap_after_ready", 32'(bus.fail_ready), 1);

        // Duplicate and overflow.
        send_fail(4'd5, 1'b0);
        chk("ovf5_used", 32'(bus.spares_used), 1);
        send_fail(4'd5, 1'b0);
        chk("ovf5dup_used", 32'(bus.spares_used), 1);
        chk("ovf5dup_fail", 32'(bus.repair_fail), 0);
        send_fail(4'd6, 1'b0);
        chk("ovf6_used", 32'(bus.spares_used), 2);
        chk("ovf6_fail", 32'(bus.repair_fail), 0);
        send_fail(4'd7, 1'b0);
        chk("ovf7_used", 32'(bus.spares_used), 2);
        chk("ovf7_fail", 32'(bus.repair_fail), 1);
        bus.bist_done = 1'b1;
        tick();
        bus.bist_done = 1'b0;
        chk("ovf_done", 32'(bus.repair_done), 1);
        chk("ovf_fail_held", 32'(bus.repair_fail), 1);
        for (int i = 0; i < 3; i++) apply_func(ovf_vec[i], $sformatf("ovf%0d", i));

        // Clear wins over a simultaneous fail report.
        bus.clear = 1'b1;
        bus.fail_valid = 1'b1;
        bus.fail_addr = 4'd8;
        tick();
        bus.clear = 1'b0;
        bus.fail_valid = 1'b0;
        chk("clrfv_ready", 32'(bus.fail_ready), 1);
        chk("clrfv_used", 32'(bus.spares_used), 0);
        chk("clrfv_done", 32'(bus.repair_done), 0);
        chk("clrfv_fail", 32'(bus.repair_fail), 0);
        tick();
        chk("clrfv_after_used", 32'(bus.spares_used), 0);

        // Pass-through before done: no remap even for a captured address.
        send_fail(4'd3, 1'b0);
        chk("pre_used", 32'(bus.spares_used), 1);
        for (int i = 0; i < 2; i++) apply_func(pre_vec[i], $sformatf("pre%0d", i));

        // Fail accepted together with bist_done.
        pulse_clear();
        send_fail(4'd2, 1'b1);
        chk("simul_used", 32'(bus.spares_used), 1);
        chk("simul_done", 32'(bus.repair_done), 1);
        chk("simul_ready", 32'(bus.fail_ready), 0);

        // bist_done arriving during CAPTURE.
        pulse_clear();
        bus.fail_valid = 1'b1;
        bus.fail_addr = 4'd4;
        tick();
        bus.fail_valid = 1'b0;
        bus.bist_done = 1'b1;
        tick();
        bus.bist_done = 1'b0;
        chk("capbd_done", 32'(bus.repair_done), 1);
        chk("capbd_used", 32'(bus.spares_used), 1);
        chk("capbd_ready", 32'(bus.fail_ready), 0);
        tick();
        chk("capbd_hold", 32'(bus.repair_done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
